// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch front end: branch-type codes, FSM encoding, reset PC default.
// Pure declarations; no logic, no latency.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BR_COND   = 2'b00,
        BR_UNCOND = 2'b01,
        BR_CALL   = 2'b10,
        BR_REG    = 2'b11
    } br_type_e;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_e;

    localparam int unsigned PC_RESET_DEFAULT = 0;

endpackage

// File: rtl/pc_gen_if.sv
// Bundle between hazard/decode + instruction memory (master side) and the PC generator (slave side).
// Wires only; fetch_ready is the memory's acceptance of pc, stall is the hazard unit's hold.
interface pc_gen_if #(
    parameter int PC_WIDTH = 16,
    parameter int COND_W   = 8,
    parameter int UNCOND_W = 11,
    parameter int LINK_W   = 6
);
    logic                stall;
    logic                fetch_ready;
    logic                br_taken;
    logic [1:0]          branch_type;
    logic                is_ret;
    logic [COND_W-1:0]   cond_offset;
    logic [UNCOND_W-1:0] uncond_offset;
    logic [LINK_W-1:0]   link_offset;
    logic [PC_WIDTH-1:0] reg_data;

    logic [PC_WIDTH-1:0] pc;
    logic                fetch_valid;
    logic [PC_WIDTH-1:0] pc_if_id;
    logic                id_valid;
    logic [PC_WIDTH-1:0] link_pc;
    logic                squash_if;
    logic                ras_empty;
    logic                ras_full;

    modport master (
        output stall, fetch_ready, br_taken, branch_type, is_ret,
               cond_offset, uncond_offset, link_offset, reg_data,
        input  pc, fetch_valid, pc_if_id, id_valid, link_pc, squash_if,
               ras_empty, ras_full
    );

    modport slave (
        input  stall, fetch_ready, br_taken, branch_type, is_ret,
               cond_offset, uncond_offset, link_offset, reg_data,
        output pc, fetch_valid, pc_if_id, id_valid, link_pc, squash_if,
               ras_empty, ras_full
    );

endinterface

// File: rtl/pc_gen_return_stack.sv
// Circular return-address stack; top is combinational, push/pop take effect on the next edge.
// No backpressure: a push when full silently overwrites the oldest entry, a pop when empty is ignored.
module return_stack #(
    parameter int PC_WIDTH  = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] push_data,
    output logic [PC_WIDTH-1:0] top,
    output logic                empty,
    output logic                full
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [PTR_W-1:0]    w_top_idx;

    // r_ptr is the next write slot, so the top lives one below it
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == CNT_W'(RAS_DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_mem[r_ptr] <= push_data;
            r_ptr        <= r_ptr + PTR_W'(1);
            if (!full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            r_ptr <= r_ptr - PTR_W'(1);
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Next-PC generator with IF/ID PC register, ID-stage branch resolution and return-address stack.
// One-cycle branch penalty; stall or !fetch_ready holds the PC, but a redirect always loads its target.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int                  PC_WIDTH  = 16,
    parameter int                  COND_W    = 8,
    parameter int                  UNCOND_W  = 11,
    parameter int                  LINK_W    = 6,
    parameter int                  RAS_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(PC_RESET_DEFAULT)
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    fsm_state_e          r_state;
    fsm_state_e          w_state_next;
    logic                w_fetch_valid;

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pc_if_id;
    logic                r_id_valid;

    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_link_pc;
    logic [PC_WIDTH-1:0] w_cond_ext;
    logic [PC_WIDTH-1:0] w_uncond_ext;
    logic [PC_WIDTH-1:0] w_link_ext;
    logic [PC_WIDTH-1:0] w_ras_top;
    logic                w_ras_empty;
    logic                w_ras_full;
    logic                w_redirect;
    logic                w_advance;
    logic                w_push;
    logic                w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        w_fetch_valid = 1'b0;
        case (r_state)
            ST_RUN:  w_fetch_valid = 1'b1;
            default: w_fetch_valid = 1'b0;
        endcase
    end

    assign w_redirect = bus.br_taken & r_id_valid & ~bus.stall & (r_state == ST_RUN);
    assign w_advance  = bus.fetch_ready & ~bus.stall;
    assign w_link_pc  = r_pc_if_id + PC_ONE;

    assign w_cond_ext   = {{(PC_WIDTH-COND_W){bus.cond_offset[COND_W-1]}}, bus.cond_offset};
    assign w_uncond_ext = {{(PC_WIDTH-UNCOND_W){bus.uncond_offset[UNCOND_W-1]}}, bus.uncond_offset};
    assign w_link_ext   = {{(PC_WIDTH-LINK_W){bus.link_offset[LINK_W-1]}}, bus.link_offset};

    always_comb begin
        w_target = bus.reg_data;
        case (bus.branch_type)
            BR_COND:   w_target = r_pc_if_id + w_cond_ext;
            BR_UNCOND: w_target = r_pc_if_id + w_uncond_ext;
            BR_CALL:   w_target = r_pc_if_id + w_link_ext;
            BR_REG:    w_target = (bus.is_ret && !w_ras_empty) ? w_ras_top : bus.reg_data;
            default:   w_target = bus.reg_data;
        endcase
    end

    // BOOT has no live request, so the reset PC is held until the first real fetch
    always_comb begin
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (bus.stall || !bus.fetch_ready || !w_fetch_valid) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = r_pc + PC_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_pc_if_id <= '0;
            r_id_valid <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_advance) begin
                r_pc_if_id <= r_pc;
                r_id_valid <= w_fetch_valid & ~w_redirect;
            end else if (w_redirect) begin
                r_id_valid <= 1'b0;
            end
        end
    end

    assign w_push = w_redirect & (bus.branch_type == BR_CALL);
    assign w_pop  = w_redirect & (bus.branch_type == BR_REG) & bus.is_ret;

    return_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_link_pc),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    assign bus.pc          = r_pc;
    assign bus.fetch_valid = w_fetch_valid;
    assign bus.pc_if_id    = r_pc_if_id;
    assign bus.id_valid    = r_id_valid;
    assign bus.link_pc     = w_link_pc;
    assign bus.squash_if   = w_redirect;
    assign bus.ras_empty   = w_ras_empty;
    assign bus.ras_full    = w_ras_full;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios plus random traffic, all against a cycle model
// built from arithmetic on plain integers and a queue standing in for the return stack.
module tb_pc_gen_unit;
    localparam int          PW     = 16;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h0010;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_gen_if #(.PC_WIDTH(PW), .COND_W(8), .UNCOND_W(11), .LINK_W(6)) bus ();

    pc_gen_unit #(
        .PC_WIDTH(PW), .COND_W(8), .UNCOND_W(11), .LINK_W(6),
        .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] m_pc;
    logic [15:0] m_pc_if_id;
    bit          m_id_valid;
    bit          m_boot;
    logic [15:0] m_ras [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sx(input int v, input int w);
        return (((v >> (w - 1)) & 1) != 0) ? v - (1 << w) : v;
    endfunction

    task automatic model_reset();
        m_pc       = RST_PC;
        m_pc_if_id = 16'h0000;
        m_id_valid = 1'b0;
        m_boot     = 1'b1;
        m_ras.delete();
    endtask

    function automatic logic [15:0] m_target();
        int t;
        case (bus.branch_type)
            2'd0:    t = int'(m_pc_if_id) + sx(int'(bus.cond_offset), 8);
            2'd1:    t = int'(m_pc_if_id) + sx(int'(bus.uncond_offset), 11);
            2'd2:    t = int'(m_pc_if_id) + sx(int'(bus.link_offset), 6);
            default: t = (bus.is_ret && m_ras.size() > 0) ? int'(m_ras[$]) : int'(bus.reg_data);
        endcase
        return 16'(t);
    endfunction

    // Compare every output against the model, then advance model and DUT by one clock.
    task automatic cycle();
        logic [15:0] n_pc;
        logic [15:0] link;
        bit          redir;
        bit          adv;
        #2;
        redir = bus.br_taken && m_id_valid && !bus.stall && !m_boot;
        adv   = bus.fetch_ready && !bus.stall;
        link  = m_pc_if_id + 16'd1;
        chk("pc", bus.pc, m_pc);
        chk("fetch_valid", bus.fetch_valid, !m_boot);
        chk("pc_if_id", bus.pc_if_id, m_pc_if_id);
        chk("id_valid", bus.id_valid, m_id_valid);
        chk("link_pc", bus.link_pc, link);
        chk("squash_if", bus.squash_if, redir);
        chk("ras_empty", bus.ras_empty, m_ras.size() == 0);
        chk("ras_full", bus.ras_full, m_ras.size() == DEPTH);
        if (redir) n_pc = m_target();
        else if (bus.stall || !bus.fetch_ready || m_boot) n_pc = m_pc;
        else n_pc = m_pc + 16'd1;
        if (redir && bus.branch_type == 2'd2) begin
            m_ras.push_back(link);
            if (m_ras.size() > DEPTH) m_ras.pop_front();
        end else if (redir && bus.branch_type == 2'd3 && bus.is_ret && m_ras.size() > 0) begin
            m_ras.pop_back();
        end
        @(posedge clk);
        #1;
        if (adv) begin
            m_pc_if_id = m_pc;
            m_id_valid = !m_boot && !redir;
        end else if (redir) begin
            m_id_valid = 1'b0;
        end
        m_pc   = n_pc;
        m_boot = 1'b0;
    endtask

    task automatic drv(input bit st, input bit fr, input bit br, input logic [1:0] ty,
                       input bit rt, input logic [15:0] rd, input int off);
        bus.stall         = st;
        bus.fetch_ready   = fr;
        bus.br_taken      = br;
        bus.branch_type   = ty;
        bus.is_ret        = rt;
        bus.reg_data      = rd;
        bus.cond_offset   = 8'(off);
        bus.uncond_offset = 11'(off);
        bus.link_offset   = 6'(off);
    endtask

    task automatic idle();
        drv(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 0);
        cycle();
    endtask

    // Leaves pc_if_id = a with id_valid set and pc = a+1.
    task automatic jump_to(input logic [15:0] a);
        drv(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, a, 0);
        cycle();
        idle();
    endtask

    initial begin
        drv(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 0);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pc", bus.pc, 16'h0010);
        chk("rst_fetch_valid", bus.fetch_valid, 0);
        chk("rst_pc_if_id", bus.pc_if_id, 0);
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_squash", bus.squash_if, 0);
        chk("rst_ras_empty", bus.ras_empty, 1);
        chk("rst_ras_full", bus.ras_full, 0);
        chk("rst_link_pc", bus.link_pc, 16'h0001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        chk("boot_pc", bus.pc, 16'h0010);
        chk("boot_fetch_valid", bus.fetch_valid, 0);
        cycle();
        chk("run0_pc", bus.pc, 16'h0010);
        chk("run0_fetch_valid", bus.fetch_valid, 1);
        cycle();
        chk("run1_pc", bus.pc, 16'h0011);
        cycle();
        chk("run2_pc", bus.pc, 16'h0012);

        jump_to(16'h0020);
        drv(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0000, -8);
        #1 chk("cond_squash", bus.squash_if, 1);
        cycle();
        chk("cond_pc", bus.pc, 16'h0018);
        chk("cond_id_squashed", bus.id_valid, 0);
        idle();
        chk("cond_tgt_id_pc", bus.pc_if_id, 16'h0018);
        chk("cond_tgt_id_valid", bus.id_valid, 1);

        jump_to(16'h0100);
        drv(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0000, 5);
        cycle();
        chk("call_pc", bus.pc, 16'h0105);
        chk("call_ras_nonempty", bus.ras_empty, 0);
        idle();
        drv(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 16'h0BAD, 0);
        cycle();
        chk("ret_pc", bus.pc, 16'h0101);
        chk("ret_ras_empty", bus.ras_empty, 1);
        idle();

        jump_to(16'h0010);
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0000, 1);
            cycle();
            idle();
        end
        chk("ras_full_after5", bus.ras_full, 1);
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 16'h0777, 0);
            cycle();
            chk("ras_ret_pc", bus.pc, 32'h15 - i);
            idle();
        end
        drv(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 16'h0777, 0);
        cycle();
        chk("ret_empty_pc", bus.pc, 16'h0777);
        chk("ret_empty_flag", bus.ras_empty, 1);
        idle();

        jump_to(16'h003F);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0000, 100);
            #1 chk("stall_no_squash", bus.squash_if, 0);
            cycle();
            chk("stall_pc", bus.pc, 16'h0040);
            chk("stall_pc_if_id", bus.pc_if_id, 16'h003F);
        end
        drv(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0ABC, 0);
        cycle();
        chk("nordy_redirect_pc", bus.pc, 16'h0ABC);
        idle();

        jump_to(16'hFFFE);
        chk("wrap_pre_pc", bus.pc, 16'hFFFF);
        idle();
        chk("wrap_pc", bus.pc, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
                int'($urandom_range(0, 2047)));
            cycle();
        end

        jump_to(16'h0200);
        drv(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0000, 3);
        cycle();
        chk("pre_rst_ras", bus.ras_empty, 0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", bus.pc, 16'h0010);
        chk("async_rst_ras_empty", bus.ras_empty, 1);
        chk("async_rst_fetch_valid", bus.fetch_valid, 0);
        chk("async_rst_id_valid", bus.id_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
# pc_gen_unit

Parametrised next-PC generator and fetch front end for the 5-stage pipeline, replacing the fixed 16-bit fetch stage. It holds the fetch PC and the IF/ID PC register, and resolves branches in ID: conditional, unconditional, call-with-link and register jump. It adds a return-address stack, a stall input and a valid/ready fetch handshake to instruction memory. It sits between the hazard unit and decode on one side and instruction memory on the other.

## Interface
- PC_WIDTH, 16, PC and address width.
- COND_W, 8, conditional offset width.
- UNCOND_W, 11, unconditional offset width.
- LINK_W, 6, call offset width.
- RAS_DEPTH, 4, return stack entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded at reset.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall; holds PC and IF/ID.
- fetch_ready  in  1  instruction memory accepts `pc` this cycle.
- br_taken  in  1  ID-stage branch resolves taken.
- branch_type  in  2  00 cond, 01 uncond, 10 call, 11 register jump.
- is_ret  in  1  with type 11: pop the RAS.
- cond_offset  in  COND_W  signed offset.
- uncond_offset  in  UNCOND_W  signed offset.
- link_offset  in  LINK_W  signed offset.
- reg_data  in  PC_WIDTH  register-jump target.
- pc  out  PC_WIDTH  fetch address.
- fetch_valid  out  1  `pc` is a live request.
- pc_if_id  out  PC_WIDTH  PC of the instruction in ID.
- id_valid  out  1  ID instruction is not squashed.
- link_pc  out  PC_WIDTH  pc_if_id+1, written to the link register on a call.
- squash_if  out  1  the IF instruction must be discarded.
- ras_empty, ras_full  out  1  RAS status.

## Operation
- Two-state FSM.
  - BOOT is entered on reset and lasts exactly one cycle after reset deasserts. In BOOT, fetch_valid=0.
  - RUN: fetch_valid=1 in every cycle.
- redirect = br_taken & id_valid & !stall & (state==RUN).
- Target selection:
  - Types 00, 01 and 10: target = pc_if_id + sign-extended offset, modulo 2^PC_WIDTH.
  - Type 11 with is_ret=0: target = reg_data.
  - Type 11 with is_ret=1: target = RAS top if the RAS is non-empty, otherwise reg_data.
- Next PC, evaluated in this priority order:
  1. redirect: target. Applies even when fetch_ready=0; the pending request is abandoned.
  2. stall=1 or fetch_ready=0: hold.
  3. Otherwise: pc+1. 2^PC_WIDTH−1 wraps to 0.
- IF/ID register:
  - advance = fetch_ready & !stall.
  - On advance: pc_if_id←pc and id_valid←fetch_valid & !redirect.
  - On redirect without advance: id_valid←0.
  - Otherwise both hold.
- squash_if = redirect, combinational.
- RAS operations:
  - A type-10 redirect pushes link_pc.
  - A type-11, is_ret=1 redirect pops the RAS if it is non-empty.
  - Push when full: the oldest entry is overwritten and the count stays at RAS_DEPTH; the stack is circular.
  - Pop when empty: no change to the stack.
  - The RAS is never touched when br_taken=0.
- Reset values:
  - pc=RESET_PC and pc_if_id=0.
  - fetch_valid=0, id_valid=0, squash_if=0.
  - RAS count=0, ras_empty=1, ras_full=0.
  - link_pc=1.

## Timing
- Sequential fetch: one PC per cycle while fetch_ready=1 and stall=0.
- Branch penalty: one cycle.
  - A redirect in cycle N places the target on `pc` in cycle N+1.
  - The instruction fetched in cycle N never becomes id_valid.
- RAS: a push in cycle N is visible to a pop in cycle N+1.
- An asynchronous reset assertion mid-operation clears all state immediately, with no dependence on the clock.
- On reset release: `pc`=RESET_PC with fetch_valid=0 for one cycle (BOOT), then fetch_valid=1.

## Structure
- Package pc_gen_pkg holds:
  - the branch-type constants BR_COND, BR_UNCOND, BR_CALL, BR_REG;
  - the FSM state encoding;
  - the RESET_PC default.
- Sub-module return_stack, parametrised by PC_WIDTH and RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full.
  - Circular pointer plus a saturating count.
- Offset sign extension and the two adders stay inline.

## Test plan
- Reset release with RESET_PC=0x0010 and fetch_ready=1 → `pc` 0x0010 for one BOOT cycle with fetch_valid=0, then 0x0010, 0x0011, 0x0012 with fetch_valid=1.
- pc_if_id=0x0020, type 00, cond_offset=8'hF8, br_taken → next `pc`=0x0018; squash_if pulses high in the redirect cycle; the following ID instruction has id_valid=0.
- Call at pc_if_id=0x0100 with link_offset=6'h05 → `pc`=0x0105 and RAS top=0x0101. A later type 11 with is_ret=1 → `pc`=0x0101 and ras_empty=1.
- RAS_DEPTH=4 with five calls (link_pc 0x11 to 0x15) → ras_full=1; four returns yield 0x15, 0x14, 0x13, 0x12; a fifth return with empty RAS and reg_data=0x0777 → `pc`=0x0777.
- stall=1 for three cycles at `pc`=0x0040 with br_taken=1 → PC and IF/ID hold and no redirect occurs. fetch_ready=0 with a redirect → `pc` loads the target anyway.
- `pc`=0xFFFF with sequential fetch → 0x0000. Reset asserted mid-stream → `pc`=RESET_PC and ras_empty=1 with no clock edge.
